// File: rtl/enokida_trace_buffer.sv
// enokida_trace_buffer: first-word-fall-through circular FIFO that sits between
// a tracer and the trace cache. While the buffer is close to full it raises a
// hysteretic lock (stall) request.
// Optional feature macro: ENOKIDA_TRACE_DROP_COUNT_EN. When it is defined,
// records lost to overflow are counted in a saturating 32-bit counter. When it
// is not defined, drop_count is tied to zero. Overflowing records are dropped
// either way.
module enokida_trace_buffer #(
    parameter int DEPTH       = 8,
    parameter int TRACE_WIDTH = 160
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TRACE_WIDTH-1:0]   trace_data_i,
    input  logic                     trace_valid_i,
    input  logic                     trace_capture_enable,
    input  logic                     flush_i,
    output logic [TRACE_WIDTH-1:0]   trace_in,
    output logic                     trace_ready,
    input  logic                     trace_ack_i,
    output logic                     lock,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [31:0]              drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    logic [TRACE_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       fill_q, fill_d;
    lock_state_e            lock_q;
    logic                   full;
    logic                   push;
    logic                   pop;

    // Head of the queue falls through combinationally from registered state.
    assign trace_ready = (fill_q != '0);
    assign trace_in    = mem_q[rd_ptr_q];
    assign fill_level  = fill_q;
    assign lock        = (lock_q == LOCKED);

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign full = (fill_q == CNT_W'(DEPTH));
    assign pop  = trace_ack_i && trace_ready;
    assign push = trace_valid_i && trace_capture_enable && (!full || pop);

    // Next pointer and occupancy. Flush discards any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_d = fill_q + CNT_W'(1);
            end else if (pop && !push) begin
                fill_d = fill_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Record storage. It is never cleared, because stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push) begin
            mem_q[wr_ptr_q] <= trace_data_i;
        end
    end

    // Lock hysteresis. It decides from the occupancy that is being committed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= UNLOCKED;
        end else begin
            case (lock_q)
                UNLOCKED: if (fill_d >= CNT_W'(DEPTH - 2)) lock_q <= LOCKED;
                LOCKED:   if (fill_d <= CNT_W'(DEPTH / 2)) lock_q <= UNLOCKED;
                default:  lock_q <= UNLOCKED;
            endcase
        end
    end

`ifdef ENOKIDA_TRACE_DROP_COUNT_EN
    logic [31:0] drop_q;
    logic        overflow;

    // An accepted-but-unstored record is a drop. A flush discards the record without counting it.
    assign overflow   = trace_valid_i && trace_capture_enable && full && !pop && !flush_i;
    assign drop_count = drop_q;

    // Saturating overflow counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (overflow && (drop_q != 32'hFFFF_FFFF)) begin
            drop_q <= drop_q + 32'd1;
        end
    end
`else
    assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_enokida_trace_buffer.sv
// Self-checking bench for enokida_trace_buffer. The reference is a queue of
// records plus a hysteretic lock flag.
module tb_enokida_trace_buffer;

    localparam int DEPTH = 8;
    localparam int TW    = 160;
`ifdef ENOKIDA_TRACE_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [TW-1:0]   data;
    logic            valid, en, flush, ack;
    logic [TW-1:0]   trace_in;
    logic            ready, lock;
    logic [3:0]      fill;
    logic [31:0]     drops;

    always #5 clk = ~clk;

    enokida_trace_buffer #(.DEPTH(DEPTH), .TRACE_WIDTH(TW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .trace_data_i        (data),
        .trace_valid_i       (valid),
        .trace_capture_enable(en),
        .flush_i             (flush),
        .trace_in            (trace_in),
        .trace_ready         (ready),
        .trace_ack_i         (ack),
        .lock                (lock),
        .fill_level          (fill),
        .drop_count          (drops)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [TW-1:0] mq[$];
    logic [31:0] mdrop = 32'd0;
    bit          mlock = 1'b0;
    logic [TW-1:0] rec_a;
    logic [31:0] drop_snap;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_step(input bit r, input bit v, input bit e, input bit a, input bit f,
                              input logic [TW-1:0] d);
        if (r) begin
            mq.delete();
            mdrop = 32'd0;
            mlock = 1'b0;
            return;
        end
        if (f) begin
            mq.delete();
            mlock = 1'b0;
            return;
        end
        if (a && mq.size() != 0) void'(mq.pop_front());
        if (v && e) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else if (DROP_EN && mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 32'd1;
        end
        if (!mlock && mq.size() >= DEPTH - 2) mlock = 1'b1;
        else if (mlock && mq.size() <= DEPTH / 2) mlock = 1'b0;
    endtask

    task automatic check_all();
        chk("fill", TW'(fill), TW'(mq.size()));
        chk("ready", TW'(ready), TW'(mq.size() != 0));
        chk("lock", TW'(lock), TW'(mlock));
        chk("drops", TW'(drops), TW'(mdrop));
        if (mq.size() != 0) chk("head", trace_in, mq[0]);
    endtask

    task automatic cyc(input bit r, input bit v, input bit e, input bit a, input bit f,
                       input logic [TW-1:0] d);
        rst = r; valid = v; en = e; ack = a; flush = f; data = d;
        @(posedge clk);
        model_step(r, v, e, a, f, d);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; en = 1'b0; ack = 1'b0; flush = 1'b0; data = '0;

        // A record presented during reset is discarded and is not counted as a drop.
        cyc(1, 1, 1, 0, 0, rnd_data());
        cyc(1, 1, 1, 1, 1, rnd_data());
        chk("rst_ready", TW'(ready), TW'(0));
        chk("rst_fill", TW'(fill), TW'(0));
        chk("rst_lock", TW'(lock), TW'(0));
        chk("rst_drops", TW'(drops), TW'(0));

        // Push in the first cycle after reset, then the record becomes visible and is acked.
        rec_a = rnd_data();
        cyc(0, 1, 1, 0, 0, rec_a);
        chk("a_ready", TW'(ready), TW'(1));
        chk("a_head", trace_in, rec_a);
        chk("a_fill", TW'(fill), TW'(1));
        cyc(0, 0, 1, 1, 0, '0);
        chk("a_gone_ready", TW'(ready), TW'(0));
        chk("a_gone_fill", TW'(fill), TW'(0));

        // An ack while empty is ignored.
        cyc(0, 0, 1, 1, 0, '0);
        chk("ack_empty_fill", TW'(fill), TW'(0));

        // Lock asserts at 6 entries and releases when the occupancy drops to 4.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 1, 0, 0, rnd_data());
            chk("lock_fill_up", TW'(lock), TW'(i == 5));
        end
        cyc(0, 0, 1, 1, 0, '0);
        chk("lock_at5", TW'(lock), TW'(1));
        cyc(0, 0, 1, 1, 0, '0);
        chk("lock_at4", TW'(lock), TW'(0));
        chk("fill_at4", TW'(fill), TW'(4));

        // Relock at 7, drop back to 5 (lock held), then flush with a push and an ack.
        cyc(0, 1, 1, 0, 0, rnd_data());
        cyc(0, 1, 1, 0, 0, rnd_data());
        cyc(0, 1, 1, 0, 0, rnd_data());
        cyc(0, 0, 1, 1, 0, '0);
        cyc(0, 0, 1, 1, 0, '0);
        chk("pre_flush_lock", TW'(lock), TW'(1));
        drop_snap = drops;
        cyc(0, 1, 1, 1, 1, rnd_data());
        chk("flush_fill", TW'(fill), TW'(0));
        chk("flush_ready", TW'(ready), TW'(0));
        chk("flush_lock", TW'(lock), TW'(0));
        chk("flush_drops", TW'(drops), TW'(drop_snap));

        // Overflow: push 10 records with no ack.
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, rnd_data());
        chk("ovf_fill", TW'(fill), TW'(8));
        chk("ovf_drops", TW'(drops), DROP_EN ? TW'(2) : TW'(0));

        // With capture disabled, a valid record is neither pushed nor dropped.
        drop_snap = drops;
        cyc(0, 1, 0, 0, 0, rnd_data());
        chk("cap_off_fill", TW'(fill), TW'(8));
        chk("cap_off_drops", TW'(drops), TW'(drop_snap));

        // While full, push and ack in the same cycle for 20 cycles so the pointers wrap.
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1, 1, 0, rnd_data());
            chk("full_pp_fill", TW'(fill), TW'(8));
        end
        chk("full_pp_drops", TW'(drops), TW'(drop_snap));
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0, '0);

        // Hold one entry while pushing and acking in the same cycle.
        cyc(0, 1, 1, 0, 0, rnd_data());
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 1, 0, rnd_data());
            chk("one_pp_fill", TW'(fill), TW'(1));
        end

        // Random traffic in alternating fill-heavy and drain-heavy phases.
        for (int i = 0; i < 800; i++) begin
            bit r, f, v, e, a;
            r = ($urandom_range(0, 149) == 0);
            f = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 7) != 0);
            a = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc(r, v, e, a, f, rnd_data());
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
